// File: rtl/mem_if_pkg.sv
// Shared encodings for the MFA/MFC memory responder: access sizes, direction and FSM states.
package mem_if_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // True when the size code is reserved or the address is not naturally aligned for it.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lsb[0];
      SZ_WORD: bad = (lsb != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: maps a right-justified access onto the four byte lanes of a word row.
module mem_lane_align
  import mem_if_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lsb,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_word,
  output logic        err,
  output logic [3:0]  byte_we,
  output logic [31:0] wr_word,
  output logic [31:0] rdata
);

  // Lane 0 (lowest address) sits in bits [31:24] and is enabled by byte_we[3].
  always_comb begin
    err     = size_misaligned(size, addr_lsb);
    byte_we = 4'b0000;
    wr_word = 32'h0000_0000;
    rdata   = 32'h0000_0000;
    if (!err) begin
      case (size)
        SZ_BYTE: begin
          byte_we = 4'b1000 >> addr_lsb;
          wr_word = {4{wdata[7:0]}};
          rdata   = (rd_word >> {~addr_lsb, 3'b000}) & 32'h0000_00FF;
        end
        SZ_HALF: begin
          byte_we = 4'b1100 >> addr_lsb;
          wr_word = {2{wdata[15:0]}};
          rdata   = (rd_word >> {~addr_lsb[1], 4'b0000}) & 32'h0000_FFFF;
        end
        SZ_WORD: begin
          byte_we = 4'b1111;
          wr_word = wdata;
          rdata   = rd_word;
        end
        default: begin
          byte_we = 4'b0000;
          wr_word = 32'h0000_0000;
          rdata   = 32'h0000_0000;
        end
      endcase
    end else begin
      byte_we = 4'b0000;
      wr_word = 32'h0000_0000;
      rdata   = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/mem_responder_256.sv
// Memory-side MFA/MFC responder: 2**ADDR_W bytes of big-endian storage with programmable wait states.
module mem_responder_256
  import mem_if_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MFA,
  input  logic              RW_RAM,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  input  logic [1:0]        DataSize,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              ERR,
  output logic              Busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              rw_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       din_r;
  logic [1:0]        size_r;
  logic [31:0]       dout_r;
  logic              mfc_r;
  logic              err_r;
  logic              busy_r;

  logic [7:0]        mem_r [DEPTH];

  logic [ADDR_W-3:0] row_s;
  logic [31:0]       rd_word_s;
  logic              complete_s;
  logic              align_err_s;
  logic [3:0]        byte_we_s;
  logic [31:0]       wr_word_s;
  logic [31:0]       rdata_s;

  assign row_s      = addr_r[ADDR_W-1:2];
  assign rd_word_s  = {mem_r[{row_s, 2'd0}], mem_r[{row_s, 2'd1}],
                       mem_r[{row_s, 2'd2}], mem_r[{row_s, 2'd3}]};
  // The access happens only on the edge that ends the wait with the initiator still asking.
  assign complete_s = (state_r == ST_WAIT) && MFA && (cnt_r == 4'd0);

  mem_lane_align u_align (
    .size     (size_r),
    .addr_lsb (addr_r[1:0]),
    .wdata    (din_r),
    .rd_word  (rd_word_s),
    .err      (align_err_s),
    .byte_we  (byte_we_s),
    .wr_word  (wr_word_s),
    .rdata    (rdata_s)
  );

  // Storage write port; deliberately outside reset so contents survive CLR.
  always_ff @(posedge CLK) begin
    if (complete_s && (rw_r == RW_WRITE)) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_we_s[3-i]) begin
          mem_r[{row_s, 2'(i)}] <= wr_word_s[31-8*i -: 8];
        end
      end
    end
  end

  // Handshake FSM with wait counter, request latches and registered outputs.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      rw_r    <= RW_READ;
      addr_r  <= '0;
      din_r   <= 32'h0000_0000;
      size_r  <= SZ_BYTE;
      dout_r  <= 32'h0000_0000;
      mfc_r   <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (MFA) begin
            rw_r    <= RW_RAM;
            addr_r  <= Address;
            din_r   <= DataIn;
            size_r  <= DataSize;
            cnt_r   <= 4'(WAIT_STATES);
            state_r <= ST_WAIT;
            busy_r  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!MFA) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= ST_DONE;
            mfc_r   <= 1'b1;
            err_r   <= align_err_s;
            if (align_err_s) begin
              dout_r <= 32'h0000_0000;
            end else if (rw_r == RW_READ) begin
              dout_r <= rdata_s;
            end
          end
        end
        ST_DONE: begin
          if (!MFA) begin
            state_r <= ST_IDLE;
            mfc_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mfc_r   <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign DataOut = dout_r;
  assign MFC     = mfc_r;
  assign ERR     = err_r;
  assign Busy    = busy_r;

endmodule

// File: tb/tb_mem_responder_256.sv
// Scoreboard bench for mem_responder_256: a byte-array model predicts each completion.
module tb_mem_responder_256;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        mfa, rw;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [1:0]  dsize;
  logic [31:0] dout;
  logic        mfc, err, busy;

  logic        z_mfa, z_rw;
  logic [7:0]  z_addr;
  logic [31:0] z_din;
  logic [1:0]  z_dsize;
  logic [31:0] z_dout;
  logic        z_mfc, z_err, z_busy;

  always #5 clk = ~clk;

  mem_responder_256 #(.WAIT_STATES(WS), .ADDR_W(8)) dut (
    .CLK(clk), .CLR(clr_n), .MFA(mfa), .RW_RAM(rw), .Address(addr), .DataIn(din),
    .DataSize(dsize), .DataOut(dout), .MFC(mfc), .ERR(err), .Busy(busy)
  );

  mem_responder_256 #(.WAIT_STATES(0), .ADDR_W(8)) dut0 (
    .CLK(clk), .CLR(clr_n), .MFA(z_mfa), .RW_RAM(z_rw), .Address(z_addr), .DataIn(z_din),
    .DataSize(z_dsize), .DataOut(z_dout), .MFC(z_mfc), .ERR(z_err), .Busy(z_busy)
  );

  typedef struct packed {
    logic [31:0] dout;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        rw;
    logic [7:0]  a;
    logic [1:0]  sz;
    logic [31:0] d;
  } req_t;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb_q[$];
  logic [7:0]  model_mem [0:255];
  logic [31:0] last_dout = 32'h0;

  function automatic exp_t model_access(input logic rw_i, input logic [7:0] a,
                                        input logic [1:0] sz, input logic [31:0] d);
    exp_t e;
    logic bad;
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    if (bad) begin
      last_dout = 32'h0;
    end else if (rw_i) begin
      case (sz)
        2'b00:   last_dout = {24'h0, model_mem[a]};
        2'b01:   last_dout = {16'h0, model_mem[a], model_mem[a+8'd1]};
        default: last_dout = {model_mem[a], model_mem[a+8'd1], model_mem[a+8'd2], model_mem[a+8'd3]};
      endcase
    end else begin
      case (sz)
        2'b00: model_mem[a] = d[7:0];
        2'b01: begin
          model_mem[a] = d[15:8]; model_mem[a+8'd1] = d[7:0];
        end
        default: begin
          model_mem[a] = d[31:24]; model_mem[a+8'd1] = d[23:16];
          model_mem[a+8'd2] = d[15:8]; model_mem[a+8'd3] = d[7:0];
        end
      endcase
    end
    e.dout = last_dout;
    e.err  = bad;
    return e;
  endfunction

  // Issue one request, push its prediction, and return at the negedge where MFC is first seen.
  task automatic run_req(input req_t r, output int edges, output logic to);
    @(negedge clk);
    rw = r.rw; addr = r.a; dsize = r.sz; din = r.d; mfa = 1'b1;
    sb_q.push_back(model_access(r.rw, r.a, r.sz, r.d));
    @(posedge clk);
    edges = 0;
    to = 1'b0;
    while (1) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (mfc) break;
      if (edges > 40) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_mfa();
    @(negedge clk);
    mfa = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clr_n = 1'b0; mfa = 1'b0; rw = 1'b1; addr = 8'h00; din = 32'h0; dsize = 2'b00;
    z_mfa = 1'b0; z_rw = 1'b1; z_addr = 8'h00; z_din = 32'h0; z_dsize = 2'b00;
    #1;
    vectors++;
    if (dout !== 32'h0 || mfc !== 1'b0 || err !== 1'b0 || busy !== 1'b0 ||
        z_dout !== 32'h0 || z_mfc !== 1'b0 || z_err !== 1'b0 || z_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: dout=%h mfc=%b err=%b busy=%b z_dout=%h z_mfc=%b, expected all zero",
               dout, mfc, err, busy, z_dout, z_mfc);
    end
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  // Shared per-entry check used by the table-driven scenario tasks below.
  task automatic test_table(input string name, input req_t tbl[]);
    int   edges;
    logic to;
    exp_t e;
    foreach (tbl[i]) begin
      run_req(tbl[i], edges, to);
      e = sb_q.pop_front();
      vectors++;
      if (to || edges != WS + 1) begin
        miscompares++;
        $display("FAIL %s[%0d] latency: got %0d edges (timeout=%b), expected %0d", name, i, edges, to, WS + 1);
      end
      vectors++;
      if (dout !== e.dout || err !== e.err) begin
        miscompares++;
        $display("FAIL %s[%0d] data: got dout=%h err=%b, expected dout=%h err=%b",
                 name, i, dout, err, e.dout, e.err);
      end
      release_mfa();
    end
  endtask

  task automatic test_word_and_subword();
    req_t tbl[];
    tbl = new[7];
    tbl[0] = '{1'b0, 8'h10, 2'b10, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 8'h10, 2'b10, 32'h0};
    tbl[2] = '{1'b1, 8'h11, 2'b00, 32'h0};
    tbl[3] = '{1'b1, 8'h12, 2'b01, 32'h0};
    tbl[4] = '{1'b1, 8'h13, 2'b00, 32'h0};
    tbl[5] = '{1'b0, 8'h12, 2'b00, 32'hFFFFFF55};
    tbl[6] = '{1'b1, 8'h10, 2'b10, 32'h0};
    test_table("word_subword", tbl);
  endtask

  task automatic test_errors();
    req_t tbl[];
    tbl = new[6];
    tbl[0] = '{1'b0, 8'h20, 2'b10, 32'hA1B2C3D4};
    tbl[1] = '{1'b1, 8'h21, 2'b01, 32'h0};
    tbl[2] = '{1'b1, 8'h20, 2'b10, 32'h0};
    tbl[3] = '{1'b0, 8'h22, 2'b10, 32'h11223344};
    tbl[4] = '{1'b1, 8'h20, 2'b10, 32'h0};
    tbl[5] = '{1'b1, 8'h24, 2'b11, 32'h0};
    test_table("errors", tbl);
  endtask

  task automatic test_hold();
    int   edges;
    logic to;
    exp_t e;
    run_req('{1'b1, 8'h20, 2'b10, 32'h0}, edges, to);
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (mfc !== 1'b1 || busy !== 1'b1 || dout !== e.dout || err !== e.err) begin
        miscompares++;
        $display("FAIL hold[%0d]: mfc=%b busy=%b dout=%h err=%b, expected mfc=1 busy=1 dout=%h err=%b",
                 i, mfc, busy, dout, err, e.dout, e.err);
      end
    end
    mfa = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (mfc !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || dout !== e.dout) begin
      miscompares++;
      $display("FAIL drop: mfc=%b err=%b busy=%b dout=%h, expected 0 0 0 dout=%h", mfc, err, busy, dout, e.dout);
    end
  endtask

  task automatic test_abort();
    logic seen;
    exp_t e;
    @(negedge clk);
    rw = 1'b0; addr = 8'h20; dsize = 2'b10; din = 32'h99998888; mfa = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mfa = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mfc) seen = 1'b1;
    end
    vectors++;
    if (seen || busy !== 1'b0 || dout !== last_dout) begin
      miscompares++;
      $display("FAIL abort: mfc_seen=%b busy=%b dout=%h, expected 0 0 dout=%h", seen, busy, dout, last_dout);
    end
    begin
      req_t tbl[];
      tbl = new[1];
      tbl[0] = '{1'b1, 8'h20, 2'b10, 32'h0};
      test_table("abort_readback", tbl);
    end
    e = '{32'h0, 1'b0};
    e.dout = e.dout;
  endtask

  task automatic test_reset_mid();
    req_t tbl[];
    tbl = new[2];
    tbl[0] = '{1'b0, 8'h30, 2'b10, 32'hCAFEF00D};
    tbl[1] = '{1'b1, 8'h10, 2'b10, 32'h0};
    test_table("pre_reset", tbl);
    @(negedge clk);
    rw = 1'b0; addr = 8'h30; dsize = 2'b10; din = 32'h12345678; mfa = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 clr_n = 1'b0;
    #1;
    vectors++;
    if (dout !== 32'h0 || mfc !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: dout=%h mfc=%b err=%b busy=%b, expected all zero", dout, mfc, err, busy);
    end
    mfa = 1'b0;
    last_dout = 32'h0;
    @(negedge clk);
    clr_n = 1'b1;
    tbl = new[1];
    tbl[0] = '{1'b1, 8'h30, 2'b10, 32'h0};
    test_table("post_reset", tbl);
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_d [2];
    int          edges;
    exp_d[0] = 32'h0;
    exp_d[1] = 32'h0BADF00D;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      z_rw = (i == 1); z_addr = 8'h08; z_dsize = 2'b10; z_din = 32'h0BADF00D; z_mfa = 1'b1;
      @(posedge clk);
      edges = 0;
      while (edges < 40) begin
        @(posedge clk);
        edges++;
        @(negedge clk);
        if (z_mfc) break;
      end
      vectors++;
      if (edges != 1 || z_mfc !== 1'b1 || z_dout !== exp_d[i] || z_err !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_wait[%0d]: edges=%0d mfc=%b dout=%h err=%b, expected 1 1 %h 0",
                 i, edges, z_mfc, z_dout, z_err, exp_d[i]);
      end
      @(negedge clk);
      z_mfa = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_word_and_subword();
    test_errors();
    test_hold();
    test_abort();
    test_reset_mid();
    test_zero_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
